// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the dmem MMIO responder.
//   - MMIO register offsets within the 16-word MMIO window
//   - STATUS register bit positions
//   - default base word address of the MMIO window
package dmem_mmio_responder_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'd0;
  localparam logic [3:0] OFF_STATUS = 4'd1;
  localparam logic [3:0] OFF_GPIO   = 4'd2;
  localparam logic [3:0] OFF_CYCLES = 4'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;

  localparam logic [11:0] MMIO_BASE_DEFAULT = 12'hFF0;

endpackage

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   push, din           : write request and data (dropped when full unless popping)
//   pop                 : read request (ignored when empty)
//   dout                : head entry, zero while empty
//   count, full, empty  : occupancy 0..DEPTH and derived flags
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Storage is not reset, so the head is masked while empty.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Responder on the processor data-memory bus. RAM-region accesses pass
// straight through to the syncram; the top 16 words hold MMIO registers
// (TX FIFO, STATUS, GPIO, CYCLES). MMIO reads are registered so both
// regions present read data one clock after the address.
// Ports:
//   clock, reset              : dmem clock, asynchronous active-high reset
//   address_dmem, data, wren  : processor request
//   q_dmem                    : read data to processor (1-clock latency)
//   ram_address/data/wren     : syncram request (wren gated in MMIO region)
//   ram_q                     : syncram registered read data
//   tx_data, tx_valid, tx_ready : TX FIFO drain port
//   gpio_out                  : GPIO output register
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_dmem,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] q_dmem,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] gpio_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  is_mmio;
  logic [3:0]            offset;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  overflow;
  logic                  ovf_set;
  logic                  wr_status;
  logic                  wr_gpio;
  logic                  wr_cycles;
  logic [DATA_WIDTH-1:0] cycles;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  sel_mmio;
  logic [DATA_WIDTH-1:0] mmio_q;

  assign is_mmio = (address_dmem[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4]);
  assign offset  = address_dmem[3:0];

  assign ram_address = address_dmem;
  assign ram_data    = data;
  assign ram_wren    = wren && !is_mmio;

  assign push      = wren && is_mmio && (offset == OFF_TXDATA);
  assign wr_status = wren && is_mmio && (offset == OFF_STATUS);
  assign wr_gpio   = wren && is_mmio && (offset == OFF_GPIO);
  assign wr_cycles = wren && is_mmio && (offset == OFF_CYCLES);
  assign pop       = tx_valid && tx_ready;
  // A simultaneous pop frees a slot, so only an unmatched push into a full FIFO overflows.
  assign ovf_set   = push && fifo_full && !pop;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (data),
    .dout  (tx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_valid = !fifo_empty;

  always_comb begin
    status                          = '0;
    status[STAT_EMPTY]              = fifo_empty;
    status[STAT_FULL]               = fifo_full;
    status[STAT_OVF]                = overflow;
    status[STAT_COUNT_LSB +: CW]    = fifo_count;
  end

  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_STATUS: rd_val = status;
      OFF_GPIO:   rd_val = gpio_out;
      OFF_CYCLES: rd_val = cycles;
      default:    rd_val = '0;
    endcase
  end

  // Register stage: read data captured from pre-update register values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_mmio <= 1'b0;
      mmio_q   <= '0;
      gpio_out <= '0;
      cycles   <= '0;
      overflow <= 1'b0;
    end else begin
      sel_mmio <= is_mmio;
      mmio_q   <= rd_val;
      if (wr_gpio) gpio_out <= data;
      cycles <= wr_cycles ? data : cycles + 1'b1;
      // Set wins over a clearing STATUS write in the same cycle.
      if (ovf_set)        overflow <= 1'b1;
      else if (wr_status) overflow <= 1'b0;
    end
  end

  assign q_dmem = sel_mmio ? mmio_q : ram_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [11:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] gpio_out;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] fq[$];
  logic        m_ovf;
  logic [31:0] m_gpio;
  logic [31:0] m_cyc;

  // behavioural syncram: registered read of old contents
  logic [31:0] ram [4096];

  dmem_mmio_responder #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .MMIO_BASE  (12'hFF0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .gpio_out     (gpio_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    ram_q <= ram[ram_address];
    if (ram_wren) ram[ram_address] <= ram_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_ovf  = 1'b0;
    m_gpio = '0;
    m_cyc  = '0;
  endtask

  // One bus cycle: drive at negedge, check pass-through, predict, check after the edge.
  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic w, input logic rdy);
    logic        mmio;
    logic [3:0]  off;
    logic [31:0] st, rv, eq;
    logic        popm, pushm, fullm, ovf_set;
    int          sz;
    address_dmem = a;
    data         = d;
    wren         = w;
    tx_ready     = rdy;
    mmio = (a[11:4] == 8'hFF);
    off  = a[3:0];
    #1;
    check("ram_wren", {31'b0, ram_wren}, {31'b0, w && !mmio});
    check("ram_addr", {20'b0, ram_address}, {20'b0, a});
    check("ram_data", ram_data, d);
    sz = fq.size();
    st = 32'(sz) * 256 + (m_ovf ? 4 : 0) + (sz == DEPTH ? 2 : 0) + (sz == 0 ? 1 : 0);
    case (off)
      4'd1:    rv = st;
      4'd2:    rv = m_gpio;
      4'd3:    rv = m_cyc;
      default: rv = 32'h0;
    endcase
    eq = mmio ? rv : ram[a];
    popm    = (sz != 0) && rdy;
    pushm   = w && mmio && (off == 4'd0);
    fullm   = (sz == DEPTH);
    ovf_set = pushm && fullm && !popm;
    if (popm) void'(fq.pop_front());
    if (pushm && !ovf_set) fq.push_back(d);
    if (w && mmio && off == 4'd1) m_ovf = 1'b0;
    if (ovf_set) m_ovf = 1'b1;
    if (w && mmio && off == 4'd2) m_gpio = d;
    m_cyc = (w && mmio && off == 4'd3) ? d : m_cyc + 32'd1;
    @(negedge clock);
    check("q_dmem", q_dmem, eq);
    check("tx_valid", {31'b0, tx_valid}, {31'b0, fq.size() != 0});
    check("tx_data", tx_data, (fq.size() != 0) ? fq[0] : 32'h0);
    check("gpio_out", gpio_out, m_gpio);
  endtask

  initial begin
    logic [11:0] ra;
    reset        = 1'b1;
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    tx_ready     = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_gpio", gpio_out, 32'h0);
    reset = 1'b0;

    // reset state of STATUS
    step(12'hFF1, 32'h0, 1'b0, 1'b0);
    check("status_after_reset", q_dmem, 32'h0000_0001);

    // RAM pass-through and GPIO
    step(12'h010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(12'h010, 32'h0, 1'b0, 1'b0);
    check("ram_readback", q_dmem, 32'hDEAD_BEEF);
    step(12'hFF2, 32'h5, 1'b1, 1'b0);
    check("gpio_write", gpio_out, 32'h5);
    step(12'hFF2, 32'h0, 1'b0, 1'b0);
    check("gpio_read", q_dmem, 32'h5);

    // overflow: 9 pushes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) step(12'hFF0, 32'(i), 1'b1, 1'b0);
    step(12'hFF1, 32'h0, 1'b0, 1'b0);
    check("status_full_ovf", q_dmem, 32'h0000_0806);
    for (int i = 1; i <= 8; i++) begin
      check("drain_head", tx_data, 32'(i));
      step(12'h020, 32'h0, 1'b0, 1'b1);
    end
    step(12'hFF1, 32'h0, 1'b0, 1'b1);
    check("status_empty_ovf", q_dmem, 32'h0000_0005);
    step(12'hFF1, 32'h0, 1'b1, 1'b0);
    step(12'hFF1, 32'h0, 1'b0, 1'b0);
    check("status_cleared", q_dmem, 32'h0000_0001);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(12'hFF0, 32'h100 + 32'(i), 1'b1, 1'b0);
    step(12'hFF0, 32'hAA, 1'b1, 1'b1);
    step(12'hFF1, 32'h0, 1'b0, 1'b0);
    check("status_push_pop_full", q_dmem, 32'h0000_0802);
    for (int i = 0; i < 8; i++) step(12'h030, 32'h0, 1'b0, 1'b1);
    check("aa_drained_last", {31'b0, tx_valid}, 32'h0);

    // CYCLES load and wrap, reserved offsets
    step(12'hFF3, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step(12'hFF3, 32'h0, 1'b0, 1'b0);
    check("cycles_load", q_dmem, 32'hFFFF_FFFE);
    step(12'hFF3, 32'h0, 1'b0, 1'b0);
    check("cycles_max", q_dmem, 32'hFFFF_FFFF);
    step(12'hFF3, 32'h0, 1'b0, 1'b0);
    check("cycles_wrap", q_dmem, 32'h0000_0000);
    for (int i = 4; i < 16; i++) step(12'hFF0 | 12'(i), 32'h0, 1'b0, 1'b0);

    // reset mid-drain
    for (int i = 0; i < 4; i++) step(12'hFF0, 32'h200 + 32'(i), 1'b1, 1'b0);
    step(12'h040, 32'h0, 1'b0, 1'b1);
    wren     = 1'b0;
    tx_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("async_rst_tx_data", tx_data, 32'h0);
    check("async_rst_gpio", gpio_out, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    step(12'hFF3, 32'h0, 1'b0, 1'b0);
    check("cycles_restart", q_dmem, 32'h0);
    step(12'hFF1, 32'h0, 1'b0, 1'b0);
    check("status_post_reset", q_dmem, 32'h0000_0001);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = 12'($urandom_range(0, 12'hFEF));
      end else if ($urandom_range(0, 1) == 1) begin
        ra = 12'hFF0 | 12'($urandom_range(0, 3));
      end else begin
        ra = 12'hFF0 | 12'($urandom_range(0, 15));
      end
      step(ra, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
